// File: rtl/multi_switch_debounce.sv
// N-channel switch debouncer: per-channel 2-flop sync, shared sample tick,
// stable-count filter, debounced level and one-clk press/release pulses.
module multi_switch_debounce #(
   parameter int CHANNELS     = 4,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 10,
   parameter bit ACTIVE_LOW   = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] sw,
   output logic [CHANNELS-1:0] db_level,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] rel
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);
   localparam logic [CHANNELS-1:0] IDLE = ACTIVE_LOW ? '1 : '0;

   logic [CHANNELS-1:0] sync1_q, sync1_d;
   logic [CHANNELS-1:0] sync2_q, sync2_d;
   logic [PW-1:0]       pcnt_q, pcnt_d;
   logic [CW-1:0]       cnt_q [CHANNELS];
   logic [CW-1:0]       cnt_d [CHANNELS];
   logic [CHANNELS-1:0] level_q, level_d;
   logic [CHANNELS-1:0] press_q, press_d;
   logic [CHANNELS-1:0] rel_q, rel_d;
   logic [CHANNELS-1:0] samp;
   logic                tick;

   always_comb begin
      sync1_d = sw;
      sync2_d = sync1_q;
      samp    = sync2_q ^ IDLE;
      tick    = (pcnt_q == P_LAST);
      pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
   end

   // Any agreeing sample clears the run; only a full run flips the level.
   always_comb begin
      level_d = level_q;
      press_d = '0;
      rel_d   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (tick) begin
            if (samp[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == C_LAST) begin
               cnt_d[i]   = '0;
               level_d[i] = samp[i];
               press_d[i] = samp[i];
               rel_d[i]   = ~samp[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= IDLE;
         sync2_q <= IDLE;
         pcnt_q  <= '0;
         level_q <= '0;
         press_q <= '0;
         rel_q   <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         pcnt_q  <= pcnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign db_level = level_q;
   assign press    = press_q;
   assign rel      = rel_q;

endmodule
